// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped IO unit: address map, register bit positions, word width.
// Latency: none (package only).
// Backpressure: none (package only).
package io_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int ADDR_WIDTH = 16;

  // Register addresses seen on the AM bus
  localparam logic [ADDR_WIDTH-1:0] IO_DATA   = 16'h0000;
  localparam logic [ADDR_WIDTH-1:0] IO_STATUS = 16'h0001;
  localparam logic [ADDR_WIDTH-1:0] IO_CTRL   = 16'h0002;

  // STATUS bit positions
  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_TX_OVF   = 5;

  // CTRL bit positions; OVF_CLR is a write-only strobe
  localparam int CTRL_RX_IE   = 0;
  localparam int CTRL_TX_IE   = 1;
  localparam int CTRL_OVF_CLR = 15;

  typedef enum logic [1:0] {
    SEL_DATA,
    SEL_STATUS,
    SEL_CTRL,
    SEL_NONE
  } io_sel_e;

  typedef struct packed {
    logic tx_ie;
    logic rx_ie;
  } ctrl_t;

  // Map a bus address onto the register it selects
  function automatic io_sel_e decode_addr(input logic [ADDR_WIDTH-1:0] a);
    case (a)
      IO_DATA:   return SEL_DATA;
      IO_STATUS: return SEL_STATUS;
      IO_CTRL:   return SEL_CTRL;
      default:   return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_if.sv
// Bundles the CPU-side register bus and the device-side TX/RX valid-ready links of the IO unit.
// Latency: none (wiring only).
// Backpressure: tx_ready / rx_ready carry the device-side flow control.
interface io_if #(
  parameter int word_width = 16
);

  // CPU register bus
  logic [15:0]           addr;
  logic                  io_oe;
  logic                  io_we;
  logic [word_width-1:0] data_in;
  logic [word_width-1:0] data_out;
  logic                  data_oe;

  // Device links
  logic [word_width-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [word_width-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  logic                  irq;

  // The IO unit side
  modport slave (
    input  addr, io_oe, io_we, data_in, tx_ready, rx_data, rx_valid,
    output data_out, data_oe, tx_data, tx_valid, rx_ready, irq
  );

  // The CPU / device side driving the IO unit
  modport master (
    output addr, io_oe, io_we, data_in, tx_ready, rx_data, rx_valid,
    input  data_out, data_oe, tx_data, tx_valid, rx_ready, irq
  );

endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO with power-of-two depth, head visible combinationally.
// Latency: a pushed word is visible at head one cycle after the push edge when the FIFO was empty.
// Backpressure: push is taken when not full, or when full with a pop in the same cycle; pop on empty is ignored.
module io_fifo #(
  parameter int word_width = 16,
  parameter int fifo_depth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [word_width-1:0] din,
  output logic                  full,
  output logic                  empty,
  output logic [word_width-1:0] head
);

  localparam int AW = $clog2(fifo_depth);
  // Depth is a power of two, so the full count is a single set MSB
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [word_width-1:0] mem_q [fifo_depth];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the same edge frees a slot
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy next-state; pointers wrap naturally modulo depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/io_unit.sv
// Memory-mapped IO port: CPU DATA/STATUS/CTRL registers in front of TX and RX FIFOs, plus interrupt.
// Latency: reads are combinational in the strobe cycle; writes/pops take effect on that edge; irq lags one cycle.
// Backpressure: rx_ready drops when RX is full (words then count as rx overflow); CPU writes to a full TX are dropped.
module io_unit
  import io_pkg::*;
#(
  parameter int word_width = WORD_WIDTH,
  parameter int fifo_depth = 4
) (
  input logic clk,
  input logic rst,
  io_if.slave bus
);

  io_sel_e               sel;
  logic                  cpu_rd, cpu_wr;

  logic                  tx_push, tx_pop, tx_full, tx_empty, tx_drop;
  logic [word_width-1:0] tx_head;
  logic                  rx_push, rx_pop, rx_full, rx_empty, rx_drop;
  logic [word_width-1:0] rx_head;

  ctrl_t                 ctrl_q, ctrl_d;
  logic                  rx_ovf_q, rx_ovf_d;
  logic                  tx_ovf_q, tx_ovf_d;
  logic                  irq_q, irq_d;
  logic                  ovf_clr;

  logic [word_width-1:0] status_w, ctrl_w, rd_mux;

  // A read wins over a simultaneous write
  assign sel    = decode_addr(bus.addr);
  assign cpu_rd = bus.io_oe;
  assign cpu_wr = bus.io_we & ~bus.io_oe;

  // TX: CPU pushes, device pops; a write to a full FIFO survives if the device pops on the same edge
  assign tx_pop  = ~tx_empty & bus.tx_ready;
  assign tx_push = cpu_wr & (sel == SEL_DATA);
  assign tx_drop = tx_push & tx_full & ~tx_pop;

  // RX: device pushes only while there is room, CPU DATA reads pop
  assign rx_push = bus.rx_valid & ~rx_full;
  assign rx_drop = bus.rx_valid & rx_full;
  assign rx_pop  = cpu_rd & (sel == SEL_DATA) & ~rx_empty;

  io_fifo #(
    .word_width(word_width),
    .fifo_depth(fifo_depth)
  ) u_tx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tx_push),
    .pop  (tx_pop),
    .din  (bus.data_in),
    .full (tx_full),
    .empty(tx_empty),
    .head (tx_head)
  );

  io_fifo #(
    .word_width(word_width),
    .fifo_depth(fifo_depth)
  ) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rx_push),
    .pop  (rx_pop),
    .din  (bus.rx_data),
    .full (rx_full),
    .empty(rx_empty),
    .head (rx_head)
  );

  // CTRL, sticky overflow flags and interrupt next-state; a new overflow beats a same-cycle clear
  always_comb begin
    ctrl_d  = ctrl_q;
    ovf_clr = 1'b0;
    if (cpu_wr && (sel == SEL_CTRL)) begin
      ctrl_d.rx_ie = bus.data_in[CTRL_RX_IE];
      ctrl_d.tx_ie = bus.data_in[CTRL_TX_IE];
      ovf_clr      = bus.data_in[CTRL_OVF_CLR];
    end
    rx_ovf_d = (rx_ovf_q & ~ovf_clr) | rx_drop;
    tx_ovf_d = (tx_ovf_q & ~ovf_clr) | tx_drop;
    irq_d    = (ctrl_q.rx_ie & ~rx_empty) | (ctrl_q.tx_ie & tx_empty);
  end

  // Control/status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= '0;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      irq_q    <= irq_d;
    end
  end

  // Read-data mux; DATA on an empty RX and unmapped addresses read as zero
  always_comb begin
    status_w              = '0;
    status_w[ST_RX_EMPTY] = rx_empty;
    status_w[ST_RX_FULL]  = rx_full;
    status_w[ST_TX_EMPTY] = tx_empty;
    status_w[ST_TX_FULL]  = tx_full;
    status_w[ST_RX_OVF]   = rx_ovf_q;
    status_w[ST_TX_OVF]   = tx_ovf_q;

    ctrl_w             = '0;
    ctrl_w[CTRL_RX_IE] = ctrl_q.rx_ie;
    ctrl_w[CTRL_TX_IE] = ctrl_q.tx_ie;

    rd_mux = '0;
    case (sel)
      SEL_DATA:   rd_mux = rx_empty ? '0 : rx_head;
      SEL_STATUS: rd_mux = status_w;
      SEL_CTRL:   rd_mux = ctrl_w;
      default:    rd_mux = '0;
    endcase
  end

  // Reset gates the bus driver directly so it releases mid-access
  assign bus.data_oe  = bus.io_oe & ~rst;
  assign bus.data_out = bus.data_oe ? rd_mux : '0;

  // Stale storage is never exposed on the device link
  assign bus.tx_valid = ~tx_empty;
  assign bus.tx_data  = tx_empty ? '0 : tx_head;
  assign bus.rx_ready = ~rx_full;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_io_unit.sv
// Bench for io_unit: queue-based reference model checked every cycle, plus directed literal expectations.
// Latency: outputs sampled on the falling edge, inputs driven 2 ns after the rising edge.
// Backpressure: tx_ready / rx_valid driven directly by the stimulus.
module tb_io_unit;
  import io_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  io_if #(.word_width(16)) bus ();

  io_unit #(
    .word_width(16),
    .fifo_depth(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- comparison helpers ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_tx[$];
  logic [15:0] m_rx[$];
  logic        m_rx_ie = 1'b0, m_tx_ie = 1'b0;
  logic        m_rx_ovf = 1'b0, m_tx_ovf = 1'b0;
  logic        m_irq = 1'b0;

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s    = 16'h0000;
    s[0] = (m_rx.size() == 0);
    s[1] = (m_rx.size() == DEPTH);
    s[2] = (m_tx.size() == 0);
    s[3] = (m_tx.size() == DEPTH);
    s[4] = m_rx_ovf;
    s[5] = m_tx_ovf;
    return s;
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    case (a)
      16'h0000: return (m_rx.size() != 0) ? m_rx[0] : 16'h0000;
      16'h0001: return m_status();
      16'h0002: return {14'b0, m_tx_ie, m_rx_ie};
      default:  return 16'h0000;
    endcase
  endfunction

  // Advance the model by one clock edge from the rules of the register map
  always @(posedge clk or posedge rst) begin : model
    int   tx_n, rx_n;
    logic rd, wr, t_pop, set_tx, set_rx, irq_next;
    if (rst) begin
      m_tx.delete();
      m_rx.delete();
      m_rx_ie  = 1'b0;
      m_tx_ie  = 1'b0;
      m_rx_ovf = 1'b0;
      m_tx_ovf = 1'b0;
      m_irq    = 1'b0;
    end else begin
      tx_n     = m_tx.size();
      rx_n     = m_rx.size();
      rd       = bus.io_oe;
      wr       = bus.io_we && !bus.io_oe;
      t_pop    = (tx_n > 0) && bus.tx_ready;
      set_tx   = 1'b0;
      set_rx   = 1'b0;
      irq_next = (m_rx_ie && rx_n > 0) || (m_tx_ie && tx_n == 0);
      if (t_pop) void'(m_tx.pop_front());
      if (wr && bus.addr == 16'h0000) begin
        if (tx_n < DEPTH || t_pop) m_tx.push_back(bus.data_in);
        else set_tx = 1'b1;
      end
      if (rd && bus.addr == 16'h0000 && rx_n > 0) void'(m_rx.pop_front());
      if (bus.rx_valid) begin
        if (rx_n < DEPTH) m_rx.push_back(bus.rx_data);
        else set_rx = 1'b1;
      end
      if (wr && bus.addr == 16'h0002) begin
        m_rx_ie = bus.data_in[0];
        m_tx_ie = bus.data_in[1];
        if (bus.data_in[15]) begin
          m_rx_ovf = 1'b0;
          m_tx_ovf = 1'b0;
        end
      end
      if (set_tx) m_tx_ovf = 1'b1;
      if (set_rx) m_rx_ovf = 1'b1;
      m_irq = irq_next;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk1("data_oe", bus.data_oe, bus.io_oe && !rst);
    chk("data_out", bus.data_out, (bus.io_oe && !rst) ? m_read(bus.addr) : 16'h0000);
    chk1("tx_valid", bus.tx_valid, m_tx.size() != 0);
    if (m_tx.size() != 0) chk("tx_data", bus.tx_data, m_tx[0]);
    chk1("rx_ready", bus.rx_ready, m_rx.size() < DEPTH);
    chk1("irq", bus.irq, m_irq);
  end

  // ---------------- stimulus tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.addr    = a;
    bus.data_in = d;
    bus.io_we   = 1'b1;
    step();
    bus.io_we   = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
    bus.addr  = a;
    bus.io_oe = 1'b1;
    @(negedge clk);
    chk(name, bus.data_out, exp);
    step();
    bus.io_oe = 1'b0;
  endtask

  task automatic rx_push(input logic [15:0] d);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] drain_exp [4];
    drain_exp = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00A5};

    bus.addr     = 16'h0000;
    bus.io_oe    = 1'b0;
    bus.io_we    = 1'b0;
    bus.data_in  = 16'h0000;
    bus.tx_ready = 1'b0;
    bus.rx_data  = 16'h0000;
    bus.rx_valid = 1'b0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Reset state
    chk1("reset tx_valid", bus.tx_valid, 1'b0);
    chk1("reset rx_ready", bus.rx_ready, 1'b1);
    chk1("reset irq", bus.irq, 1'b0);
    rst = 1'b0;
    rd(IO_STATUS, 16'h0005, "reset status");

    // TX delivery
    wr(IO_DATA, 16'h1234);
    wr(IO_DATA, 16'hBEEF);
    chk1("tx valid after writes", bus.tx_valid, 1'b1);
    chk("tx head first", bus.tx_data, 16'h1234);
    bus.tx_ready = 1'b1;
    step();
    chk("tx head second", bus.tx_data, 16'hBEEF);
    step();
    bus.tx_ready = 1'b0;
    chk1("tx drained", bus.tx_valid, 1'b0);

    // RX fill and overflow
    for (int i = 1; i <= 5; i++) begin
      bus.rx_data  = 16'(i);
      bus.rx_valid = 1'b1;
      step();
      if (i == 4) chk1("rx_ready after 4th push", bus.rx_ready, 1'b0);
    end
    bus.rx_valid = 1'b0;
    rd(IO_STATUS, 16'h0016, "status rx full ovf");
    for (int i = 1; i <= 4; i++) rd(IO_DATA, 16'(i), "rx data read");
    rd(IO_DATA, 16'h0000, "rx read when empty");
    rd(IO_STATUS, 16'h0015, "status rx ovf sticky");
    wr(IO_CTRL, 16'h8000);
    rd(IO_STATUS, 16'h0005, "status after ovf clear");

    // RX push and pop on the same edge
    rx_push(16'h0AAA);
    bus.rx_data  = 16'h0BBB;
    bus.rx_valid = 1'b1;
    rd(IO_DATA, 16'h0AAA, "rx pop with push");
    bus.rx_valid = 1'b0;
    rd(IO_DATA, 16'h0BBB, "rx second word");
    rd(IO_STATUS, 16'h0005, "status rx empty again");

    // TX full, drop and clear
    for (int i = 0; i < 4; i++) wr(IO_DATA, 16'h00A0 + 16'(i));
    rd(IO_STATUS, 16'h0009, "status tx full");
    wr(IO_DATA, 16'h00A4);
    rd(IO_STATUS, 16'h0029, "status tx ovf");
    wr(IO_CTRL, 16'h8000);
    rd(IO_STATUS, 16'h0009, "status tx ovf cleared");
    bus.tx_ready = 1'b1;
    wr(IO_DATA, 16'h00A5);
    bus.tx_ready = 1'b0;
    rd(IO_STATUS, 16'h0009, "status full write with pop");
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tx drain order", bus.tx_data, drain_exp[i]);
      step();
    end
    bus.tx_ready = 1'b0;
    chk1("tx empty after drain", bus.tx_valid, 1'b0);

    // Read and write strobes together: only the read happens
    bus.addr    = IO_DATA;
    bus.data_in = 16'h7777;
    bus.io_oe   = 1'b1;
    bus.io_we   = 1'b1;
    @(negedge clk);
    chk("oe+we read data", bus.data_out, 16'h0000);
    step();
    bus.io_oe = 1'b0;
    bus.io_we = 1'b0;
    chk1("oe+we write ignored", bus.tx_valid, 1'b0);

    // Interrupts
    wr(IO_CTRL, 16'h0001);
    chk1("irq idle", bus.irq, 1'b0);
    rx_push(16'h0055);
    chk1("irq right after push", bus.irq, 1'b0);
    step();
    chk1("irq one cycle after push", bus.irq, 1'b1);
    rd(IO_DATA, 16'h0055, "irq data read");
    chk1("irq still high after read edge", bus.irq, 1'b1);
    step();
    chk1("irq falls", bus.irq, 1'b0);
    wr(IO_CTRL, 16'h0002);
    chk1("tx irq lag", bus.irq, 1'b0);
    step();
    chk1("tx irq on empty", bus.irq, 1'b1);
    rd(IO_CTRL, 16'h0002, "ctrl readback");
    wr(IO_CTRL, 16'h7FFF);
    rd(IO_CTRL, 16'h0003, "ctrl other bits zero");
    wr(IO_CTRL, 16'h0000);

    // Unmapped and read-only addresses
    wr(16'h0003, 16'hFFFF);
    rd(16'h0003, 16'h0000, "unmapped read");
    rd(16'h8000, 16'h0000, "high unmapped read");
    wr(IO_STATUS, 16'hFFFF);
    rd(IO_STATUS, 16'h0005, "status read-only");

    // Reset mid-stream
    for (int i = 0; i < 3; i++) wr(IO_DATA, 16'h0C00 + 16'(i));
    chk1("tx valid before reset", bus.tx_valid, 1'b1);
    bus.addr  = IO_STATUS;
    bus.io_oe = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk1("tx_valid drops on reset", bus.tx_valid, 1'b0);
    chk("tx_data in reset", bus.tx_data, 16'h0000);
    chk1("rx_ready in reset", bus.rx_ready, 1'b1);
    chk1("data_oe in reset", bus.data_oe, 1'b0);
    chk("data_out in reset", bus.data_out, 16'h0000);
    step();
    step();
    bus.io_oe = 1'b0;
    rst       = 1'b0;
    rd(IO_STATUS, 16'h0005, "status after mid reset");
    wr(IO_DATA, 16'h0C0C);
    chk("first write after reset", bus.tx_data, 16'h0C0C);
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/io_unit.md
IO_UNIT -- requirements
Module: io_unit

Interface
REQ-001 Parameter: word_width, 16, width of the bus word and FIFO entries.
REQ-002 Parameter: fifo_depth, 4, number of entries in each FIFO; must be a power of two, at least 2.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: addr  input  16  port address presented by the AM register.
REQ-006 Port: io_oe  input  1  CPU read strobe from the control unit.
REQ-007 Port: io_we  input  1  CPU write strobe from the control unit.
REQ-008 Port: data_in  input  16  CPU bus write data.
REQ-009 Port: data_out  output  16  read data driven toward the CPU bus.
REQ-010 Port: data_oe  output  1  high when data_out must drive the bus.
REQ-011 Port: tx_data  output  16  outbound word to the external device.
REQ-012 Port: tx_valid  output  1  outbound word available.
REQ-013 Port: tx_ready  input  1  device accepts the outbound word.
REQ-014 Port: rx_data  input  16  inbound word from the external device.
REQ-015 Port: rx_valid  input  1  inbound word offered.
REQ-016 Port: rx_ready  output  1  the block accepts the inbound word.
REQ-017 Port: irq  output  1  interrupt request to the CPU.

Function
REQ-018 Address map: 0x0000 DATA; 0x0001 STATUS, read-only; 0x0002 CTRL, read/write; every other address reads 0x0000 and ignores writes.
REQ-019 STATUS bits: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] rx_ovf (sticky), [5] tx_ovf (sticky); [15:6] read as 0.
REQ-020 CTRL bits: [0] rx_ie, [1] tx_ie; writing bit [15] as 1 clears both overflow flags; bit [15] reads 0; other bits read 0.
REQ-021 Reads are combinational:
- data_oe = io_oe and not rst.
- data_out is valid in the same cycle io_oe is high, because the control unit captures it on that clock edge.
- When data_oe is low, data_out = 0x0000.
REQ-022 DATA read:
- RX FIFO not empty: returns the RX head; the head is popped at the clock edge ending the io_oe cycle.
- RX FIFO empty: returns 0x0000; no pop.
REQ-023 DATA write:
- TX FIFO not full: data_in is pushed at the edge where io_we is high.
- TX FIFO full: the word is dropped and tx_ovf is set.
REQ-024 io_oe and io_we both high in the same cycle: the read is performed; the write is ignored.
REQ-025 A strobe held for N cycles performs N accesses; the control unit guarantees single-cycle strobes.
REQ-026 TX side:
- tx_valid = TX FIFO not empty; tx_data = TX head.
- A pop occurs on any edge with tx_valid and tx_ready both high.
REQ-027 RX side:
- rx_ready = RX FIFO not full.
- A push of rx_data occurs on any edge with rx_valid and rx_ready both high.
- rx_ovf is set on any edge with rx_valid high and the FIFO full.
REQ-028 Simultaneous push and pop on the same FIFO:
- Both take effect and the count is unchanged.
- This holds when full on the TX side: a CPU write while tx_ready pops is accepted and tx_ovf stays clear.
- When empty, a pop has no effect and only the push takes effect.
REQ-029 The pointers are log2(fifo_depth) bits and wrap modulo fifo_depth; the count is log2(fifo_depth)+1 bits, ranging from 0 to fifo_depth.
REQ-030 The overflow-clear write and a new overflow event in the same cycle: the flag ends set.
REQ-031 irq = (rx_ie and not rx_empty) or (tx_ie and tx_empty), registered; it follows its inputs with one cycle of latency.

Reset
REQ-032 rst asserted, asynchronously and at any time including mid-access, forces:
- FIFO pointers and counts to 0;
- CTRL, rx_ovf, tx_ovf and irq to 0;
- tx_valid = 0, rx_ready = 1, data_oe = 0, data_out = 0x0000, tx_data = 0x0000.
REQ-033 FIFO storage contents need no reset.
REQ-034 The first access is honored on the first rising edge after rst is deasserted.

Structure
REQ-035 Shared package io_pkg holds the address constants (IO_DATA, IO_STATUS, IO_CTRL), the STATUS and CTRL bit positions, and word_width.
REQ-036 A single sub-module io_fifo (parameters word_width, fifo_depth; push, pop, full, empty, head outputs) is instantiated twice, once for TX and once for RX.
REQ-037 There is no further hierarchy.

Verification
REQ-038 Reset scenario: after reset, reading STATUS returns 0x0005 (rx_empty, tx_empty); tx_valid = 0; rx_ready = 1; irq = 0.
REQ-039 TX scenario: write 0x1234 then 0xBEEF to DATA with tx_ready = 0 -> tx_valid = 1 and tx_data = 0x1234; raise tx_ready for 2 cycles -> 0x1234 then 0xBEEF are delivered, then tx_valid = 0.
REQ-040 RX overflow scenario: push 5 words 0x0001..0x0005 on rx -> rx_ready = 0 after the 4th push and STATUS reads 0x0016; four DATA reads return 0x0001..0x0004; a fifth read returns 0x0000.
REQ-041 TX full scenario: fill TX with 4 words at tx_ready = 0, then write a 5th -> it is dropped and STATUS bit 5 = 1; then write CTRL = 0x8000 -> STATUS bit 5 = 0. Separately, with TX full, write a 5th word while tx_ready = 1 -> the word is accepted and tx_ovf stays 0.
REQ-042 Interrupt scenario: write CTRL = 0x0001, push one rx word -> irq rises one cycle after the push; read DATA -> irq falls one cycle later.
REQ-043 Reset-mid-operation scenario: assert rst mid-stream with 3 words in TX -> tx_valid drops immediately; after release, STATUS reads 0x0005.
